// File: rtl/cag_rgm_rfs_master_pkg.sv
// Shared types for the command-to-register-file bridge.
// Holds the FSM state encoding and the response status codes.
package cag_rgm_rfs_master_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      RSP_OK      = 2'b00,
      RSP_INVALID = 2'b01,
      RSP_TIMEOUT = 2'b10
   } rsp_status_e;

endpackage

// File: rtl/cag_rgm_rfs_master_if.sv
// Command/response streams plus register-file slave bus.
// The master modport is the bridge; slave is everything around it.
interface cag_rgm_rfs_master_if #(
   parameter int ADDR_WIDTH       = 6,
   parameter int WRITE_DATA_WIDTH = 64,
   parameter int READ_DATA_WIDTH  = 64
);
   logic                        cmd_valid;
   logic                        cmd_ready;
   logic                        cmd_write;
   logic [ADDR_WIDTH-1:0]       cmd_addr;
   logic [WRITE_DATA_WIDTH-1:0] cmd_wdata;
   logic                        rsp_valid;
   logic                        rsp_ready;
   logic [READ_DATA_WIDTH-1:0]  rsp_rdata;
   logic [1:0]                  rsp_status;
   logic [ADDR_WIDTH-1:0]       address;
   logic                        wen;
   logic                        ren;
   logic [WRITE_DATA_WIDTH-1:0] write_data;
   logic [READ_DATA_WIDTH-1:0]  read_data;
   logic                        access_done;
   logic                        invalid_address;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      output cmd_ready,
      output rsp_valid, rsp_rdata, rsp_status,
      input  rsp_ready,
      output address, wen, ren, write_data,
      input  read_data, access_done, invalid_address
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      input  cmd_ready,
      input  rsp_valid, rsp_rdata, rsp_status,
      output rsp_ready,
      input  address, wen, ren, write_data,
      output read_data, access_done, invalid_address
   );
endinterface

// File: rtl/cag_rgm_rfs_timeout_cnt.sv
// Saturating WAIT-cycle counter with clear/enable.
// expired flags the cycle in which the count reaches TIMEOUT_CYCLES.
module cag_rgm_rfs_timeout_cnt #(
   parameter int TIMEOUT_CYCLES = 1152
) (
   input  logic clk,
   input  logic res,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] MAX = CW'(TIMEOUT_CYCLES);

   logic [CW-1:0] cnt_d;
   logic [CW-1:0] cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (cnt_q != MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign expired = enable && !clear && (cnt_d == MAX);

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/cag_rgm_rfs_master.sv
// Single-outstanding bridge from a cmd/rsp stream to the register file
// slave port, with bounded wait for access_done.
module cag_rgm_rfs_master
   import cag_rgm_rfs_master_pkg::*;
#(
   parameter int ADDR_WIDTH       = 6,
   parameter int WRITE_DATA_WIDTH = 64,
   parameter int READ_DATA_WIDTH  = 64,
   parameter int TIMEOUT_CYCLES   = 1152
) (
   input  logic                   clk,
   input  logic                   res,
   cag_rgm_rfs_master_if.master   bus,
   output logic                   busy,
   output logic                   stray_done
);
   localparam logic [1:0] IDLE  = 2'(ST_IDLE);
   localparam logic [1:0] ISSUE = 2'(ST_ISSUE);
   localparam logic [1:0] WAIT  = 2'(ST_WAIT);
   localparam logic [1:0] RESP  = 2'(ST_RESP);

   logic [1:0]                  state_d, state_q;
   logic                        write_d, write_q;
   logic [ADDR_WIDTH-1:0]       address_d, address_q;
   logic [WRITE_DATA_WIDTH-1:0] wdata_d, wdata_q;
   logic                        wen_d, wen_q;
   logic                        ren_d, ren_q;
   logic [READ_DATA_WIDTH-1:0]  rdata_d, rdata_q;
   logic [1:0]                  status_d, status_q;
   logic                        stray_d, stray_q;
   logic                        expired;

   cag_rgm_rfs_timeout_cnt #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_tmo (
      .clk    (clk),
      .res    (res),
      .clear  (state_q == ISSUE),
      .enable (state_q == WAIT),
      .expired(expired)
   );

   always_comb begin
      state_d   = state_q;
      write_d   = write_q;
      address_d = address_q;
      wdata_d   = wdata_q;
      wen_d     = 1'b0;
      ren_d     = 1'b0;
      rdata_d   = rdata_q;
      status_d  = status_q;
      stray_d   = bus.access_done && (state_q != WAIT);
      unique case (state_q)
         IDLE: begin
            if (bus.cmd_valid) begin
               address_d = bus.cmd_addr;
               write_d   = bus.cmd_write;
               if (bus.cmd_write) wdata_d = bus.cmd_wdata;
               wen_d     = bus.cmd_write;
               ren_d     = !bus.cmd_write;
               state_d   = ISSUE;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            // completion beats a timeout landing in the same cycle
            if (bus.access_done) begin
               status_d = bus.invalid_address ? RSP_INVALID : RSP_OK;
               rdata_d  = (!write_q && !bus.invalid_address)
                        ? bus.read_data : '0;
               state_d  = RESP;
            end else if (expired) begin
               status_d = RSP_TIMEOUT;
               rdata_d  = '0;
               state_d  = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q   <= IDLE;
         write_q   <= 1'b0;
         address_q <= '0;
         wdata_q   <= '0;
         wen_q     <= 1'b0;
         ren_q     <= 1'b0;
         rdata_q   <= '0;
         status_q  <= RSP_OK;
         stray_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         write_q   <= write_d;
         address_q <= address_d;
         wdata_q   <= wdata_d;
         wen_q     <= wen_d;
         ren_q     <= ren_d;
         rdata_q   <= rdata_d;
         status_q  <= status_d;
         stray_q   <= stray_d;
      end
   end

   assign bus.cmd_ready  = (state_q == IDLE) && !res;
   assign bus.rsp_valid  = (state_q == RESP);
   assign bus.rsp_rdata  = rdata_q;
   assign bus.rsp_status = status_q;
   assign bus.address    = address_q;
   assign bus.write_data = wdata_q;
   assign bus.wen        = wen_q;
   assign bus.ren        = ren_q;
   assign busy           = (state_q != IDLE);
   assign stray_done     = stray_q;
endmodule
